// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// LOADER_CHECKSUM_EN adds a trailing checksum state to the load sequence.
package loader_pkg;

  localparam int unsigned HEADER_BYTES = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    StLen,
    StData,
    StCsum,
    StDone
  } state_e;
`else
  typedef enum logic [1:0] {
    StLen,
    StData,
    StDone
  } state_e;
`endif

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus the memory DMA write port of the loader.
interface program_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        dma_enable;
  logic [31:0] dma_address;
  logic [31:0] dma_data;

  // Host side: supplies bytes, observes the DMA port.
  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  dma_enable,
    input  dma_address,
    input  dma_data
  );

  // Loader side.
  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output dma_enable,
    output dma_address,
    output dma_data
  );

endinterface

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shifter; word_done_o pulses with the 4th byte and
// word_o presents the completed word in that same cycle.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    // Shift right so the first byte ends up in bits 7:0.
    word_o      = {byte_i, shift_q[31:8]};
    word_done_o = byte_valid_i && (cnt_q == 2'(HEADER_BYTES - 1));
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 32'd0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_o;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program from a byte link into memory via DMA writes.
// Optional LOADER_CHECKSUM_EN: one trailing XOR checksum byte is verified.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned WORD_NUM = 2048
) (
  input  logic             clock,
  input  logic             reset,
  program_loader_if.slave  bus,
  input  logic             reload,
  output logic             cpu_start,
  output logic             load_error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e StAfterData = StCsum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        dma_en_q, dma_en_d;
  logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic        asm_valid;
  logic        asm_done;
  logic [31:0] asm_word;

  assign bus.rx_ready    = (state_q != StDone) && !reload;
  assign accept          = bus.rx_valid && bus.rx_ready;
  assign asm_valid       = accept && ((state_q == StLen) || (state_q == StData));
  assign bus.dma_enable  = dma_en_q;
  assign bus.dma_address = addr_q;
  assign bus.dma_data    = data_q;
  assign cpu_start       = (state_q == StDone);
  assign load_error      = err_q;

  word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (reload),
    .byte_valid_i (asm_valid),
    .byte_i       (bus.rx_data),
    .word_done_o  (asm_done),
    .word_o       (asm_word)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    dma_en_d = 1'b0;
    err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (reload) begin
      state_d = StLen;
      count_d = 32'd0;
      idx_d   = 32'd0;
      err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = 8'd0;
`endif
    end else begin
      case (state_q)
        StLen: begin
          if (asm_done) begin
            count_d = asm_word;
            idx_d   = 32'd0;
            state_d = (asm_word != 32'd0) ? StData : StAfterData;
          end
        end
        StData: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) csum_d = csum_q ^ bus.rx_data;
`endif
          if (asm_done) begin
            // Out-of-range words are still consumed but never written.
            if (idx_q < WORD_NUM) begin
              dma_en_d = 1'b1;
              addr_d   = idx_q;
              data_d   = asm_word;
            end else begin
              err_d = 1'b1;
            end
            idx_d = idx_q + 32'd1;
            if ((idx_q + 32'd1) == count_q) state_d = StAfterData;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCsum: begin
          if (accept) begin
            if (bus.rx_data != csum_q) err_d = 1'b1;
            state_d = StDone;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StLen;
      count_q  <= 32'd0;
      idx_q    <= 32'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      dma_en_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dma_en_q <= dma_en_d;
      err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (WORD_NUM=2); adapts to LOADER_CHECKSUM_EN.
module tb_program_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reload = 1'b0;
  logic cpu_start;
  logic load_error;

  program_loader_if bus ();

  program_loader #(.WORD_NUM(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .reload     (reload),
    .cpu_start  (cpu_start),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // DMA write log and accepted-byte counter; both only ever grow.
  logic [31:0] log_addr [32];
  logic [31:0] log_data [32];
  int log_n = 0;
  int acc_n = 0;

  always @(negedge clock) begin
    if (bus.dma_enable && log_n < 32) begin
      log_addr[log_n] <= bus.dma_address;
      log_data[log_n] <= bus.dma_data;
      log_n <= log_n + 1;
    end
  end

  always @(posedge clock) begin
    if (!reset && bus.rx_valid && bus.rx_ready) acc_n <= acc_n + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    forever begin
      #1 ok = bus.rx_ready;
      @(posedge clock);
      if (ok) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: byte %02h not accepted, want accepted within 50 cycles", b);
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reload();
    bus.rx_valid = 1'b0;
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (bus.dma_enable !== 1'b0) begin bad++; $display("FAIL reset_dma_enable: got %b want 0", bus.dma_enable); end
    total++; if (bus.dma_address !== 32'd0) begin bad++; $display("FAIL reset_dma_address: got %h want 0", bus.dma_address); end
    total++; if (bus.dma_data !== 32'd0) begin bad++; $display("FAIL reset_dma_data: got %h want 0", bus.dma_data); end
    total++; if (cpu_start !== 1'b0) begin bad++; $display("FAIL reset_cpu_start: got %b want 0", cpu_start); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL reset_load_error: got %b want 0", load_error); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int base;
    base = log_n;
    send_word(32'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h2A);
`endif
    idle(2);
    total++; if (log_n - base !== 2) begin bad++; $display("FAIL basic_write_count: got %0d want 2", log_n - base); end
    total++; if (log_addr[base] !== 32'd0 || log_data[base] !== 32'h12345678) begin
      bad++; $display("FAIL basic_write0: got (%h,%h) want (0,12345678)", log_addr[base], log_data[base]); end
    total++; if (log_addr[base+1] !== 32'd1 || log_data[base+1] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic_write1: got (%h,%h) want (1,deadbeef)", log_addr[base+1], log_data[base+1]); end
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL basic_cpu_start: got %b want 1", cpu_start); end
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL basic_rx_ready: got %b want 0", bus.rx_ready); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL basic_load_error: got %b want 0", load_error); end
  endtask

  task automatic test_zero_len();
    int base;
    pulse_reload();
    base = log_n;
    send_word(32'd0);
    #1;
`ifdef LOADER_CHECKSUM_EN
    total++; if (cpu_start !== 1'b0) begin bad++; $display("FAIL zero_cpu_start_early: got %b want 0", cpu_start); end
    send_byte(8'h00);
    #1;
`endif
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL zero_cpu_start: got %b want 1", cpu_start); end
    idle(2);
    total++; if (log_n - base !== 0) begin bad++; $display("FAIL zero_no_write: got %0d writes want 0", log_n - base); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL zero_load_error: got %b want 0", load_error); end
  endtask

  task automatic test_overflow();
    int base;
    int acc_base;
    pulse_reload();
    base = log_n;
    acc_base = acc_n;
    send_word(32'd3);
    send_word(32'h04030201);
    send_word(32'h08070605);
    send_word(32'h0C0B0A09);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h0C);
`endif
    idle(2);
    total++; if (log_n - base !== 2) begin bad++; $display("FAIL ovf_write_count: got %0d want 2", log_n - base); end
    total++; if (log_addr[base] !== 32'd0 || log_data[base] !== 32'h04030201) begin
      bad++; $display("FAIL ovf_write0: got (%h,%h) want (0,04030201)", log_addr[base], log_data[base]); end
    total++; if (log_addr[base+1] !== 32'd1 || log_data[base+1] !== 32'h08070605) begin
      bad++; $display("FAIL ovf_write1: got (%h,%h) want (1,08070605)", log_addr[base+1], log_data[base+1]); end
`ifdef LOADER_CHECKSUM_EN
    total++; if (acc_n - acc_base !== 17) begin bad++; $display("FAIL ovf_bytes: got %0d want 17", acc_n - acc_base); end
`else
    total++; if (acc_n - acc_base !== 16) begin bad++; $display("FAIL ovf_bytes: got %0d want 16", acc_n - acc_base); end
`endif
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL ovf_load_error: got %b want 1", load_error); end
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL ovf_cpu_start: got %b want 1", cpu_start); end
  endtask

  task automatic test_reload();
    int base;
    int acc_before;
    pulse_reload();
    #1;
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL reload_clears_error: got %b want 0", load_error); end
    total++; if (cpu_start !== 1'b0) begin bad++; $display("FAIL reload_clears_start: got %b want 0", cpu_start); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reload_rx_ready: got %b want 1", bus.rx_ready); end
    @(negedge clock);
    base = log_n;
    send_word(32'd2);
    send_word(32'hDDCCBBAA);
    send_byte(8'h11);
    send_byte(8'h22);
    reload = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h33;
    acc_before = acc_n;
    #1;
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL reload_blocks_ready: got %b want 0", bus.rx_ready); end
    @(negedge clock);
    reload = 1'b0;
    bus.rx_valid = 1'b0;
    total++; if (acc_n !== acc_before) begin bad++; $display("FAIL reload_byte_dropped: got %0d accepted want 0", acc_n - acc_before); end
    send_word(32'd1);
    send_word(32'h11223344);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    idle(2);
    total++; if (log_n - base !== 2) begin bad++; $display("FAIL reload_write_count: got %0d want 2", log_n - base); end
    total++; if (log_addr[base+1] !== 32'd0 || log_data[base+1] !== 32'h11223344) begin
      bad++; $display("FAIL reload_new_write: got (%h,%h) want (0,11223344)", log_addr[base+1], log_data[base+1]); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL reload_load_error: got %b want 0", load_error); end
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL reload_cpu_start: got %b want 1", cpu_start); end
  endtask

  task automatic test_gaps();
    int base;
    pulse_reload();
    base = log_n;
    send_word(32'd1);
    send_byte(8'hEF);
    idle(3);
    send_byte(8'hCD);
    idle(1);
    send_byte(8'hAB);
    idle(5);
    send_byte(8'h89);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(2);
    total++; if (log_n - base !== 1) begin bad++; $display("FAIL gaps_write_count: got %0d want 1", log_n - base); end
    total++; if (log_addr[base] !== 32'd0 || log_data[base] !== 32'h89ABCDEF) begin
      bad++; $display("FAIL gaps_write: got (%h,%h) want (0,89abcdef)", log_addr[base], log_data[base]); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_reload();
    send_word(32'd1);
    send_word(32'h08040201);
    send_byte(8'h0F);
    idle(2);
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL csum_good_error: got %b want 0", load_error); end
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL csum_good_start: got %b want 1", cpu_start); end
    pulse_reload();
    send_word(32'd1);
    send_word(32'h08040201);
    send_byte(8'h0E);
    idle(2);
    total++; if (load_error !== 1'b1) begin bad++; $display("FAIL csum_bad_error: got %b want 1", load_error); end
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL csum_bad_start: got %b want 1", cpu_start); end
  endtask
`endif

  task automatic test_reset_mid();
    int base;
    pulse_reload();
    base = log_n;
    send_word(32'd2);
    send_word(32'h55667788);
    send_byte(8'h01);
    send_byte(8'h02);
    bus.rx_data = 8'h03;
    #2;
    reset = 1'b1;
    #1;
    total++; if (log_n - base !== 1) begin bad++; $display("FAIL rmid_pre_writes: got %0d want 1", log_n - base); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL rmid_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (bus.dma_enable !== 1'b0) begin bad++; $display("FAIL rmid_dma_enable: got %b want 0", bus.dma_enable); end
    total++; if (bus.dma_address !== 32'd0) begin bad++; $display("FAIL rmid_dma_address: got %h want 0", bus.dma_address); end
    total++; if (bus.dma_data !== 32'd0) begin bad++; $display("FAIL rmid_dma_data: got %h want 0", bus.dma_data); end
    total++; if (cpu_start !== 1'b0) begin bad++; $display("FAIL rmid_cpu_start: got %b want 0", cpu_start); end
    total++; if (load_error !== 1'b0) begin bad++; $display("FAIL rmid_load_error: got %b want 0", load_error); end
    @(negedge clock);
    @(negedge clock);
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    base = log_n;
    send_word(32'd1);
    send_word(32'h11335577);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(2);
    total++; if (log_n - base !== 1) begin bad++; $display("FAIL rmid_new_count: got %0d want 1", log_n - base); end
    total++; if (log_addr[base] !== 32'd0 || log_data[base] !== 32'h11335577) begin
      bad++; $display("FAIL rmid_new_write: got (%h,%h) want (0,11335577)", log_addr[base], log_data[base]); end
    total++; if (cpu_start !== 1'b1) begin bad++; $display("FAIL rmid_cpu_start_after: got %b want 1", cpu_start); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clock);
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_reload();
    test_gaps();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORD_NUM, default 2048, meaning the number of writable memory words; addresses >= WORD_NUM are out of range.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx_valid  input  1  a received byte is present on rx_data.
REQ-005 SHALL have port rx_data  input  8  received byte.
REQ-006 SHALL have port rx_ready  output  1  loader accepts the byte this cycle.
REQ-007 SHALL have port reload  input  1  one-cycle request to restart loading.
REQ-008 SHALL have ports dma_enable (output, 1), dma_address (output, 32) and dma_data (output, 32), which form the memory DMA write port.
REQ-009 SHALL have port cpu_start  output  1  program loaded; CPU may run.
REQ-010 SHALL have port load_error  output  1  sticky error for the current load.

Function
REQ-011 SHALL use states LEN (header), DATA, CSUM (present only with the macro in REQ-027) and DONE.
REQ-012 SHALL accept a byte exactly on cycles where rx_valid && rx_ready; rx_ready = (state != DONE) && !reload.
REQ-013 SHALL, in LEN, assemble 4 bytes little-endian into a 32-bit word count N.
REQ-014 SHALL, after the 4th header byte, go to DATA if N > 0, otherwise to CSUM/DONE.
REQ-015 SHALL, in DATA, assemble every 4 accepted bytes little-endian into a word; the first byte goes to bits 7:0.
REQ-016 SHALL assert dma_enable for exactly one cycle, the cycle after the 4th byte of word k is accepted, with dma_address = k and dma_data = the assembled word.
REQ-017 SHALL hold dma_enable low at all other times; dma_address and dma_data are don't-care while dma_enable is low.
REQ-018 SHALL suppress dma_enable for word indices k >= WORD_NUM, still consume those bytes, and set load_error.
REQ-019 SHALL leave DATA after word N-1 is complete; the word counter is 32-bit and SHALL NOT wrap for any N in use.
REQ-020 SHALL, in DONE, drive cpu_start=1 and rx_ready=0, and stay in DONE until reload or reset.
REQ-021 SHALL, on reload in any state, next cycle enter LEN, clear byte and word counters, cpu_start and load_error, and issue no pending DMA write.
REQ-022 SHALL let reload win when it coincides with rx_valid; that byte is not consumed.
REQ-023 SHALL tolerate rx_valid gaps of any length mid-word with no change to partial state.

Reset
REQ-024 SHALL, on reset, asynchronously enter LEN with all counters zero.
REQ-025 SHALL hold these output reset values: rx_ready=1 (when reload=0), dma_enable=0, dma_address=0, dma_data=0, cpu_start=0, load_error=0.
REQ-026 SHALL abort any load cleanly on reset mid-operation; the partial word is never written.

Configuration
REQ-027 SHALL, with LOADER_CHECKSUM_EN defined, keep an XOR of all DATA bytes and accept one extra byte in CSUM.
REQ-028 SHALL, with LOADER_CHECKSUM_EN defined, set load_error if the CSUM byte differs from that XOR, then go to DONE either way.
REQ-029 SHALL, with LOADER_CHECKSUM_EN undefined, omit the CSUM state and XOR register; DATA (or LEN with N=0) goes directly to DONE.

Structure
REQ-030 SHALL place the state enum type and the constant HEADER_BYTES=4 in shared package loader_pkg.
REQ-031 SHALL use one sub-module, word_assembler, a byte-to-32-bit little-endian shifter with a 2-bit byte counter and a word_done pulse, instantiated once and reused for the header and data words.

Verification
REQ-032 SHALL cover: bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> dma writes (0, 0x12345678) and (1, 0xDEADBEEF), then cpu_start=1 and rx_ready=0.
REQ-033 SHALL cover: header N=0 -> no dma_enable; cpu_start=1 one cycle after the 4th byte (no-checksum build).
REQ-034 SHALL cover: WORD_NUM=2, N=3 -> writes to addresses 0 and 1 only, 12 data bytes consumed, load_error=1, cpu_start=1.
REQ-035 SHALL cover: reload after 2 bytes of word 1, then a fresh 1-word load -> no write for the aborted word; new write at address 0; load_error=0.
REQ-036 SHALL cover: LOADER_CHECKSUM_EN, N=1, data 01 02 04 08, CSUM byte 0x0F -> load_error=0; CSUM byte 0x0E -> load_error=1; cpu_start=1 in both cases.
REQ-037 SHALL cover: reset asserted mid-DATA with rx_valid held high -> outputs take reset values immediately, and the next load begins at a header.
